// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared AES key-schedule definitions (package aes_pkg): FSM state encoding,
// key/round size constants, the Rcon lookup and RotWord.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package aes_pkg;

  localparam int AES_NK = 4;   // key length in 32-bit words (AES-128 only)
  localparam int AES_NR = 10;  // number of rounds (AES-128 only)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Round constant for rounds 1..10; every other index yields 0.
  function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Cyclic left rotation of a word by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Handshake bundle between the key scheduler and its consumer.
// Latency: n/a (wiring only). Backpressure: key_valid/key_ready, outputs hold while stalled.
// Ports: start, key_in, key_ready (consumer -> scheduler); round_key, round_idx,
//        key_valid, busy, done (scheduler -> consumer).
interface aes_inv_key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/aes_inv_key_schedule_sub_word.sv
// AES SubWord: four parallel S-box byte lookups (SubTable) on a 32-bit word.
// Latency: 0 cycles, purely combinational. Backpressure: none.
// Ports: din (32-bit word in), dout (substituted word out).

// One AES S-box byte lookup from a constant table.
module SubTable (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Entry 0 sits in the top byte, entry 255 in the bottom byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;
  assign base = 11'd2047 - {din, 3'b000};
  assign dout = SBOX[base -: 8];
endmodule

module aes_sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  for (genvar i = 0; i < 4; i++) begin : g_byte
    SubTable u_tbl (
      .din  (din[8*i +: 8]),
      .dout (dout[8*i +: 8])
    );
  end
endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption key scheduler: emits round keys 10 down to 0, one per handshake.
// Latency: 1 cycle start->first key (11 with AES_KEY_FWD_DERIVE_EN), then 1 key/cycle.
// Backpressure: key_valid/key_ready; round_key/round_idx hold while stalled.
// Ports: clk, rst (async, active-high); bus (slave modport): start/key_in load a key
//        in IDLE, round_key/round_idx/key_valid/key_ready stream the schedule,
//        busy = not IDLE, done = one-cycle pulse after round 0 is taken.
// Option: define AES_KEY_FWD_DERIVE_EN to accept the cipher key and expand it
//         forward to round 10 first; otherwise key_in must be the round-10 key.
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  aes_inv_key_schedule_if.slave  bus
);

  state_t       state, state_nxt;
  logic [127:0] cur_key;
  logic [3:0]   cnt;
  logic         done_q;
  logic         accept;

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  p1, p2, p3;
  logic [31:0]  sub_in, sub_out, t0;
  logic [3:0]   rc_idx;
  logic [127:0] inv_key;

  assign {a0, a1, a2, a3} = cur_key;
  assign accept = (state == ST_EMIT) && bus.key_ready;

  // Undo the forward XOR chain; p3 is the previous round's last word.
  assign p3 = a3 ^ a2;
  assign p2 = a2 ^ a1;
  assign p1 = a1 ^ a0;

  // The single SubWord instance serves both directions: forward expansion
  // uses the current last word and Rcon of the next round; the reverse walk
  // uses the recovered previous last word and Rcon of the current round.
`ifdef AES_KEY_FWD_DERIVE_EN
  logic         fwd_sel;
  logic [31:0]  n1, n2, n3;
  logic [127:0] fwd_key;

  assign fwd_sel = (state == ST_FWD);
  assign rc_idx  = fwd_sel ? (cnt + 4'd1) : cnt;
  assign sub_in  = fwd_sel ? rot_word(a3) : rot_word(p3);
  assign n1      = a1 ^ t0;
  assign n2      = a2 ^ n1;
  assign n3      = a3 ^ n2;
  assign fwd_key = {t0, n1, n2, n3};
`else
  assign rc_idx  = cnt;
  assign sub_in  = rot_word(p3);
`endif

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  assign t0      = a0 ^ sub_out ^ {aes_rcon(rc_idx), 24'h0};
  assign inv_key = {t0, p1, p2, p3};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef AES_KEY_FWD_DERIVE_EN
          state_nxt = ST_FWD;
`else
          state_nxt = ST_EMIT;
`endif
        end
      end
`ifdef AES_KEY_FWD_DERIVE_EN
      ST_FWD:  if (cnt == 4'(AES_NR - 1)) state_nxt = ST_EMIT;
`endif
      ST_EMIT: if (accept && (cnt == 4'd0)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Key/round datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_key <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cur_key <= bus.key_in;
`ifdef AES_KEY_FWD_DERIVE_EN
            cnt     <= 4'd0;
`else
            cnt     <= 4'(AES_NR);
`endif
          end
        end
`ifdef AES_KEY_FWD_DERIVE_EN
        ST_FWD: begin
          cur_key <= fwd_key;
          cnt     <= cnt + 4'd1;
        end
`endif
        ST_EMIT: begin
          if (accept) begin
            if (cnt != 4'd0) begin
              cur_key <= inv_key;
              cnt     <= cnt - 4'd1;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: decoded from registered state only, nothing from key_ready.
  always_comb begin
    bus.key_valid = (state == ST_EMIT);
    bus.busy      = (state != ST_IDLE);
  end

  assign bus.round_key = cur_key;
  assign bus.round_idx = cnt;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
module tb_aes_inv_key_schedule;

`ifdef AES_KEY_FWD_DERIVE_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           care;
  } exp_t;

  logic clk;
  logic rst;
  aes_inv_key_schedule_if kif ();

  aes_inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int extra_hs = 0;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] rk [0:10];
  logic [127:0] zk10;
  bit           prev_hold = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops on handshakes, hold checks while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (kif.done) done_cnt++;
      if (prev_hold && kif.key_valid) begin
        chk("hold_key", kif.round_key, prev_key);
        chk("hold_idx", 128'(kif.round_idx), 128'(prev_idx));
      end
      if (kif.key_valid && kif.key_ready) begin
        if (sb.size() == 0) extra_hs++;
        else begin
          mon_e = sb.pop_front();
          chk("round_idx", 128'(kif.round_idx), 128'(mon_e.idx));
          if (mon_e.care) chk($sformatf("round_key%0d", mon_e.idx), kif.round_key, mon_e.key);
        end
      end
      prev_hold = kif.key_valid && !kif.key_ready;
      prev_key  = kif.round_key;
      prev_idx  = kif.round_idx;
    end
  end

  task automatic step(input bit bp);
    @(posedge clk);
    #1;
    kif.key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_full();
    for (int r = 10; r >= 0; r--) sb.push_back('{idx: 4'(r), key: rk[r], care: 1'b1});
  endtask

  // Zero-key schedule: only the end points are pinned down.
  task automatic push_zero();
    for (int r = 10; r >= 0; r--)
      sb.push_back('{idx: 4'(r), key: (r == 10) ? zk10 : 128'h0, care: (r == 10) || (r == 0)});
  endtask

  task automatic do_start(input logic [127:0] k);
    @(posedge clk);
    #1;
    kif.start  = 1'b1;
    kif.key_in = k;
    push_full();
    step(1'b0);
    kif.start = 1'b0;
    chk("busy_after_start", 128'(kif.busy), 128'd1);
  endtask

  task automatic check_latency();
    int lat = 0;
    while (!kif.key_valid && lat < 50) begin
      step(1'b0);
      lat++;
    end
    chk("first_key_latency", 128'(lat), FWD ? 128'd10 : 128'd0);
  endtask

  task automatic wait_idx(input logic [3:0] idx, input bit bp);
    int n = 0;
    while (!(kif.key_valid && kif.round_idx == idx) && n < 300) begin
      step(bp);
      n++;
    end
    chk("reach_idx", 128'(kif.round_idx), 128'(idx));
  endtask

  task automatic wait_done(input bit bp, input bit b2b);
    int n = 0;
    while (!kif.done && n < 400) begin
      step(bp);
      n++;
    end
    chk("done_seen", 128'(kif.done), 128'd1);
    chk("busy_in_done_cycle", 128'(kif.busy), 128'd0);
    if (b2b) begin
      kif.start  = 1'b1;
      kif.key_in = FWD ? 128'h0 : zk10;
      push_zero();
      step(1'b0);
      kif.start = 1'b0;
      chk("b2b_busy", 128'(kif.busy), 128'd1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_round_key"}, kif.round_key, 128'h0);
    chk({tag, "_round_idx"}, 128'(kif.round_idx), 128'h0);
    chk({tag, "_key_valid"}, 128'(kif.key_valid), 128'h0);
    chk({tag, "_busy"}, 128'(kif.busy), 128'h0);
    chk({tag, "_done"}, 128'(kif.done), 128'h0);
  endtask

  initial begin
    int d0;
    logic [127:0] main_key;
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    main_key = FWD ? rk[0] : rk[10];

    rst = 1'b1;
    kif.start = 1'b0;
    kif.key_in = '0;
    kif.key_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Run 1: ready held high, full sequence and a single done pulse.
    d0 = done_cnt;
    do_start(main_key);
    check_latency();
    wait_done(1'b0, 1'b0);
    step(1'b0);
    step(1'b0);
    chk("done_pulses_run1", 128'(done_cnt - d0), 128'd1);

    // Run 2: random backpressure, plus a start that must be ignored mid-run.
    d0 = done_cnt;
    do_start(main_key);
    check_latency();
    wait_idx(4'd5, 1'b1);
    kif.start  = 1'b1;
    kif.key_in = 128'hdeadbeef0123456789abcdeffedcba98;
    step(1'b1);
    kif.start = 1'b0;
    wait_done(1'b1, 1'b0);
    step(1'b0);
    step(1'b0);
    chk("done_pulses_run2", 128'(done_cnt - d0), 128'd1);

    // Run 3: asynchronous reset in the middle of the schedule.
    do_start(main_key);
    wait_idx(4'd6, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrun_reset");
    sb.delete();
    step(1'b0);
    rst = 1'b0;
    step(1'b0);

    // Run 4 then 5: restart from scratch, second start lands in the done cycle.
    d0 = done_cnt;
    do_start(main_key);
    check_latency();
    wait_done(1'b0, 1'b1);
    wait_done(1'b0, 1'b0);
    step(1'b0);
    step(1'b0);
    chk("done_pulses_b2b", 128'(done_cnt - d0), 128'd2);

    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    chk("unexpected_handshakes", 128'(extra_hs), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
